// File: rtl/switch_reader_pkg.sv
// Shared field layout for the switch_reader read word.
// Latency: n/a (constants and a pure packing function).
// Backpressure: n/a.
package switch_reader_pkg;

   localparam int SW_LSB    = 0;
   localparam int SW_W      = 10;
   localparam int KEY_LSB   = 10;
   localparam int KEY_W     = 4;
   localparam int PRESS_LSB = 14;
   localparam int PRESS_W   = 4;
   localparam int RDATA_W   = 32;

   // Assemble the read word; bits above the press field are always zero.
   function automatic logic [RDATA_W-1:0] pack_rdata(
      input logic [SW_W-1:0]    sw,
      input logic [KEY_W-1:0]   key_pressed,
      input logic [PRESS_W-1:0] press
   );
      logic [RDATA_W-1:0] d;
      d = '0;
      d[SW_LSB +: SW_W]       = sw;
      d[KEY_LSB +: KEY_W]     = key_pressed;
      d[PRESS_LSB +: PRESS_W] = press;
      return d;
   endfunction

endpackage

// File: rtl/switch_reader_debounce_bit.sv
// Two-flop synchronizer followed by a hold-time debouncer for one input bit.
// Latency: 2 sync cycles plus DEBOUNCE_CYCLES cycles before a new level is accepted.
// Backpressure: none; free-running on every clock.
module debounce_bit
   import switch_reader_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic din,
   output logic level
);

   localparam int            CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] count;

   // Bring the asynchronous input into the clock domain.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_LEVEL;
         sync <= RESET_LEVEL;
      end else begin
         meta <= din;
         sync <= meta;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
   // the counter stops at LAST so it can never wrap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level <= RESET_LEVEL;
         count <= '0;
      end else if (sync == level) begin
         count <= '0;
      end else if (count == LAST) begin
         level <= sync;
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/switch_reader.sv
// Debounced slide-switch / push-button reader with read-to-clear press flags.
// Latency: o_ready and o_rdata valid one cycle after the i_request rising edge.
// Backpressure: initiator holds i_request until it sees o_ready; a held request is one read.
module switch_reader
   import switch_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_request,
   output logic [RDATA_W-1:0]   o_rdata,
   output logic                 o_ready,
   input  logic [SW_W-1:0]      SW,
   input  logic [KEY_W-1:0]     KEY
);

   logic [SW_W-1:0]    sw_level;
   logic [KEY_W-1:0]   key_level;
   logic [KEY_W-1:0]   key_prev;
   logic [KEY_W-1:0]   key_fall;
   logic [PRESS_W-1:0] press;
   logic               request_prev;
   logic               read_edge;

   for (genvar i = 0; i < SW_W; i++) begin : g_sw
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b0)
      ) u_db (
         .clock   (i_clock),
         .reset_n (i_reset_n),
         .din     (SW[i]),
         .level   (sw_level[i])
      );
   end

   // Buttons idle high, so their debouncers reset to the released level.
   for (genvar i = 0; i < KEY_W; i++) begin : g_key
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b1)
      ) u_db (
         .clock   (i_clock),
         .reset_n (i_reset_n),
         .din     (KEY[i]),
         .level   (key_level[i])
      );
   end

   assign read_edge = i_request & ~request_prev;
   // A press is a debounced 1->0 transition; key_prev resets high so reset never looks like a press.
   assign key_fall  = key_prev & ~key_level;

   // Request edge tracking and one-cycle acknowledge.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         request_prev <= 1'b0;
         o_ready      <= 1'b0;
      end else begin
         request_prev <= i_request;
         o_ready      <= i_request;
      end
   end

   // Press flags: a read clears them, but a press arriving on the same edge still wins.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         key_prev <= '1;
         press    <= '0;
      end else begin
         key_prev <= key_level;
         press    <= (read_edge ? '0 : press) | key_fall;
      end
   end

   // Capture the read word on the request edge and hold it until the next read.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_rdata <= '0;
      end else if (read_edge) begin
         o_rdata <= pack_rdata(sw_level, ~key_level, press);
      end
   end

endmodule

// File: tb/tb_switch_reader.sv
// Directed self-checking bench for switch_reader with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// A new input level is accepted 6 edges after it is applied (2 sync + 4 debounce).
module tb_switch_reader;

   logic        clk;
   logic        rst_n;
   logic        request;
   logic [31:0] rdata;
   logic        ready;
   logic [9:0]  sw;
   logic [3:0]  key;

   int checks;
   int fails;

   switch_reader #(.DEBOUNCE_CYCLES(4)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .i_request (request),
      .o_rdata   (rdata),
      .o_ready   (ready),
      .SW        (sw),
      .KEY       (key)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle read pulse; returns captured data, ready after edge, ready after drop.
   task automatic do_read(output logic [31:0] data, output logic rdy_hit, output logic rdy_drop);
      request = 1'b1;
      step(1);
      data    = rdata;
      rdy_hit = ready;
      request = 1'b0;
      step(1);
      rdy_drop = ready;
   endtask

   task automatic test_reset;
      logic [31:0] d; logic h, l;
      rst_n = 1'b0; request = 1'b0; sw = '0; key = 4'hF;
      #1;
      checks++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready); end
      checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
      step(2);
      rst_n = 1'b1;
      step(2);
      do_read(d, h, l);
      checks++; if (h !== 1'b1) begin fails++; $display("FAIL first_read_ready: got %b want 1", h); end
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL first_read_data: got %h want 00000000", d); end
      checks++; if (l !== 1'b0) begin fails++; $display("FAIL first_read_drop: got %b want 0", l); end
   endtask

   task automatic test_switches;
      logic [31:0] d; logic h, l;
      sw = 10'h2A5;
      step(8);
      do_read(d, h, l);
      checks++; if (d !== 32'h000002A5) begin fails++; $display("FAIL sw_read: got %h want 000002a5", d); end
      step(3);
      checks++; if (rdata !== 32'h000002A5) begin fails++; $display("FAIL sw_hold: got %h want 000002a5", rdata); end
      checks++; if (ready !== 1'b0) begin fails++; $display("FAIL sw_idle_ready: got %b want 0", ready); end
   endtask

   task automatic test_glitch;
      logic [31:0] d; logic h, l;
      sw = '0;
      step(8);
      sw[0] = 1'b1;
      step(3);
      sw[0] = 1'b0;
      step(8);
      do_read(d, h, l);
      checks++; if (d[0] !== 1'b0) begin fails++; $display("FAIL glitch_bit0: got %b want 0", d[0]); end
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL glitch_word: got %h want 00000000", d); end
   endtask

   task automatic test_key_press;
      logic [31:0] d; logic h, l;
      key = 4'b1011;
      step(8);
      key = 4'hF;
      step(8);
      do_read(d, h, l);
      checks++; if (d !== 32'h00010000) begin fails++; $display("FAIL press_flag_read: got %h want 00010000", d); end
      do_read(d, h, l);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL press_flag_cleared: got %h want 00000000", d); end
   endtask

   task automatic test_held_request;
      logic [31:0] d; logic h, l;
      key = 4'b1101;
      step(8);
      request = 1'b1;
      checks++; if (ready !== 1'b0) begin fails++; $display("FAIL held_ready_before: got %b want 0", ready); end
      for (int i = 0; i < 5; i++) begin
         step(1);
         checks++; if (ready !== 1'b1) begin fails++; $display("FAIL held_ready_cycle%0d: got %b want 1", i, ready); end
         checks++; if (rdata !== 32'h00008800) begin fails++; $display("FAIL held_rdata_cycle%0d: got %h want 00008800", i, rdata); end
      end
      request = 1'b0;
      step(1);
      checks++; if (ready !== 1'b0) begin fails++; $display("FAIL held_ready_after: got %b want 0", ready); end
      checks++; if (rdata !== 32'h00008800) begin fails++; $display("FAIL held_rdata_after: got %h want 00008800", rdata); end
      do_read(d, h, l);
      checks++; if (d !== 32'h00000800) begin fails++; $display("FAIL held_flag_once: got %h want 00000800", d); end
      key = 4'hF;
      step(8);
   endtask

   // Debounced level changes on edge 6, the press flag is raised on edge 7;
   // the read edge is placed on edge 7 so clear and set collide.
   task automatic test_coincide;
      logic [31:0] d; logic h, l;
      key = 4'b0111;
      step(6);
      do_read(d, h, l);
      checks++; if (d !== 32'h00002000) begin fails++; $display("FAIL coincide_pre_flag: got %h want 00002000", d); end
      do_read(d, h, l);
      checks++; if (d !== 32'h00022000) begin fails++; $display("FAIL coincide_flag_kept: got %h want 00022000", d); end
      key = 4'hF;
      step(8);
      checks++; if (rdata !== 32'h00022000) begin fails++; $display("FAIL coincide_hold: got %h want 00022000", rdata); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d; logic h, l;
      key = 4'b1110;
      request = 1'b1;
      step(4);
      checks++; if (ready !== 1'b1) begin fails++; $display("FAIL mid_ready_before: got %b want 1", ready); end
      rst_n = 1'b0;
      #1;
      checks++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_reset_ready: got %b want 0", ready); end
      checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL mid_reset_rdata: got %h want 00000000", rdata); end
      request = 1'b0;
      key = 4'hF;
      step(2);
      rst_n = 1'b1;
      step(8);
      do_read(d, h, l);
      checks++; if (d[14] !== 1'b0) begin fails++; $display("FAIL mid_reset_flag0: got %b want 0", d[14]); end
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL mid_reset_word: got %h want 00000000", d); end
      checks++; if (h !== 1'b1) begin fails++; $display("FAIL mid_reset_ready_after: got %b want 1", h); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_switches();
      test_glitch();
      test_key_press();
      test_held_request();
      test_coincide();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/switch_reader.md
SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: number of consecutive cycles an input must hold a new level before that level is accepted; legal range 2..2^20.
REQ-002 SHALL have port i_clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_request, input, 1: bus read request, level held by the initiator until o_ready is seen.
REQ-005 SHALL have port o_rdata, output, 32: read data, valid while o_ready=1.
REQ-006 SHALL have port o_ready, output, 1: read acknowledge.
REQ-007 SHALL have port SW, input, 10: slide switches; asynchronous; 1=on.
REQ-008 SHALL have port KEY, input, 4: push buttons; asynchronous; active-low (0=pressed).

Function
REQ-009 SHALL pass each of the 14 input bits through a 2-flop synchronizer before any other use.
REQ-010 SHALL keep, per bit, a stable level and a counter; counter clears whenever the synchronized level equals the stable level.
REQ-011 SHALL increment the counter while the synchronized level differs from the stable level; when the counter reaches DEBOUNCE_CYCLES-1 with the level still different, the stable level SHALL take the synchronized level and the counter SHALL clear.
REQ-012 SHALL size the counter as clog2(DEBOUNCE_CYCLES) bits; it SHALL never wrap.
REQ-013 SHALL set press flag i when the stable KEY[i] level goes 1->0; a release (0->1) SHALL NOT set or clear flags.
REQ-014 SHALL detect a read as a rising edge of i_request (i_request=1 and previous-cycle i_request=0); a held i_request SHALL count as one read.
REQ-015 On a detected read, o_rdata SHALL capture: bits 9:0 = stable SW; bits 13:10 = inverted stable KEY (1=pressed); bits 17:14 = press flags; bits 31:18 = 0.
REQ-016 Press flags SHALL clear on the same edge as the read capture (read-to-clear).
REQ-017 If a new press edge and a read coincide on the same bit, the flag SHALL end up 1 and o_rdata SHALL show the pre-edge flag value.
REQ-018 o_rdata SHALL hold its last captured value between reads.
REQ-019 o_ready SHALL equal i_request delayed by exactly one cycle; o_ready SHALL be 1 in the cycle after the read edge, with o_rdata already valid.
REQ-020 Deasserting i_request SHALL drop o_ready one cycle later; no other state SHALL change.

Reset
REQ-021 Asserting i_reset_n=0 SHALL immediately set: o_ready=0, o_rdata=0, press flags=0, counters=0, previous-request=0, SW synchronizers and stable levels=0, KEY synchronizers and stable levels=1 (released).
REQ-022 Reset SHALL be honoured mid-debounce and mid-read; after release, no press flag SHALL be set by the reset values themselves.

Structure
REQ-023 Shared package SHALL hold the field constants: SW_LSB=0, SW_W=10, KEY_LSB=10, KEY_W=4, PRESS_LSB=14, PRESS_W=4.
REQ-024 Synchronizer plus debounce SHALL be one sub-module, debounce_bit (parameters DEBOUNCE_CYCLES and RESET_LEVEL), instantiated 14 times.
REQ-025 Read capture, press flags and o_ready SHALL live in switch_reader.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, then read with SW=0, KEY=4'hF -> o_ready=1 one cycle after request; o_rdata=32'h0.
REQ-027 SW set to 10'h2A5 and held for 8 cycles, then read -> o_rdata=32'h000002A5.
REQ-028 SW[0] glitch to 1 for 3 cycles, then back to 0, then read -> o_rdata[0]=0.
REQ-029 KEY[2] held 0 for 8 cycles, released, then read -> o_rdata=32'h00010000; second read -> 32'h0.
REQ-030 KEY[1] held 0, i_request held high for 5 cycles -> one capture showing bits 11 and 15 set; o_ready high for 5 cycles, starting one cycle after the request; flag cleared once.
REQ-031 i_reset_n pulsed low during KEY[0] debounce (counter=2) -> all outputs 0 immediately; after release, read -> bit 14 = 0.
